mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch bus (stb/ack) and data-memory bus (stb/ack/wr_en).
- Sits between the core and a single-ported memory or bus bridge.
- Serialises requests with data-side priority, a bounded-starvation guarantee for fetch, and a per-transaction timeout.
- Each requester sees an unchanged stb/ack protocol.

Parameters:
AW, 32, address width
DW, 32, data width
D_MAX_STREAK, 4, max consecutive D grants while I is pending before I is forced through (≥1)
TIMEOUT, 255, cycles in BUSY without i_m_ack before abort (≥1)
TO_W, 8, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_i_stb  in  1  fetch request
i_i_addr  in  AW  fetch address
o_i_ack  out  1  fetch done, 1-cycle pulse
o_i_data  out  DW  fetch read data, valid with o_i_ack
i_d_stb  in  1  data request
i_d_wr_en  in  1  1=write, 0=read
i_d_addr  in  AW  data address
i_d_wr_data  in  DW  store data
o_d_ack  out  1  data done, 1-cycle pulse
o_d_data  out  DW  load data, valid with o_d_ack
o_m_stb  out  1  memory request, held until ack
o_m_wr_en  out  1  memory write enable
o_m_addr  out  AW  memory address
o_m_wr_data  out  DW  memory write data
o_m_src  out  1  owner of current transaction (0=I, 1=D)
i_m_ack  in  1  memory ack, 1-cycle pulse
i_m_data  in  DW  memory read data, valid with i_m_ack
o_bus_err  out  1  1-cycle pulse with the ack of a timed-out transaction

Behaviour:
- Async reset: state=IDLE, all outputs 0, streak and timeout counters 0. Reset mid-transaction abandons it; no ack is issued.
- States: IDLE, BUSY, RESP.
- IDLE, requests are sampled:
  - Neither stb: stay.
  - Only one stb: grant it.
  - Both stb: grant D unless streak==D_MAX_STREAK, then grant I.
- On grant, register into outputs: o_m_stb=1, addr, wr_en (0 for I), wr_data (0 for I), o_m_src. Go to BUSY.
- Streak counter:
  - +1 on each D grant made while i_i_stb=1, saturating at D_MAX_STREAK.
  - Cleared on any I grant.
  - Cleared on a D grant with i_i_stb=0.
- BUSY:
  - o_m_* held stable and the timeout counter increments each cycle.
  - On i_m_ack: clear o_m_stb. Register i_m_data into the owner's data output (D reads only; D writes return 0) and pulse the owner's ack next cycle. Go to RESP.
  - If the counter reaches TIMEOUT with no ack: clear o_m_stb, pulse the owner's ack with data=0 and o_bus_err=1. Go to RESP.
- RESP: the ack pulse is visible this cycle, requests are not sampled, and the state returns to IDLE next cycle.
- Ack and data outputs are 0 outside RESP. Data outputs are not held after the ack.
- Requester rule: stb, addr, wr_en and wr_data stay stable until ack. A stb still high in the cycle after ack is a new request.
- Latency:
  - Request sampled in IDLE at cycle 0 → o_m_stb at cycle 1.
  - Memory ack at cycle k≥1 → requester ack at k+1 → IDLE at k+2.
  - Zero-wait memory gives 2 cycles request-to-ack and 3-cycle throughput.
- i_m_ack in IDLE or RESP (late ack after a timeout) is ignored.
- Requester stb dropped while BUSY on its behalf: the transaction still completes and the ack is still issued.
- The timeout counter clears on entry to BUSY.

Test Plan:
- I read only: i_i_stb=1, addr=0x100, memory acks 1 cycle after o_m_stb with 0xDEADBEEF → o_m_addr=0x100, o_m_src=0, o_i_ack pulse with o_i_data=0xDEADBEEF, 3 cycles after request; o_d_ack stays 0.
- D write: i_d_stb=1, wr_en=1, addr=0x2000, data=0x12345678 → o_m_wr_en=1, o_m_wr_data=0x12345678, o_m_src=1, o_d_ack pulse with o_d_data=0.
- Simultaneous I and D requests, both held asserted and re-requested after each ack, D_MAX_STREAK=4, zero-wait memory → grant sequence D,D,D,D,I,D,D,D,D,I; I never waits more than 4 D transactions.
- Timeout with TIMEOUT=8: D read, memory never acks → o_m_stb high exactly 8 cycles, then o_d_ack=1, o_bus_err=1, o_d_data=0. An i_m_ack injected 2 cycles later produces no ack.
- Reset mid-op: assert rst_n=0 while BUSY on an I fetch → all outputs 0 asynchronously. After release with no stb, the arbiter stays IDLE and issues no ack.
- Spurious ack: i_m_ack=1 while IDLE with no requests → no o_i_ack or o_d_ack, and the state stays IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch and data buses with D priority,
// bounded fetch starvation and a per-transaction timeout.
module mem_bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int D_MAX_STREAK = 4,
  parameter int TIMEOUT      = 255,
  parameter int TO_W         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_i_stb,
  input  logic [AW-1:0] i_i_addr,
  output logic          o_i_ack,
  output logic [DW-1:0] o_i_data,
  input  logic          i_d_stb,
  input  logic          i_d_wr_en,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wr_data,
  output logic          o_d_ack,
  output logic [DW-1:0] o_d_data,
  output logic          o_m_stb,
  output logic          o_m_wr_en,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wr_data,
  output logic          o_m_src,
  input  logic          i_m_ack,
  input  logic [DW-1:0] i_m_data,
  output logic          o_bus_err
);
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2;
  localparam int SW = $clog2(D_MAX_STREAK + 1);
  logic [1:0] state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TO_W-1:0] to_q, to_d;
  logic m_stb_q, m_stb_d, m_wr_en_q, m_wr_en_d, m_src_q, m_src_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wr_data_q, m_wr_data_d;
  logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, bus_err_q, bus_err_d;
  logic [DW-1:0] i_data_q, i_data_d, d_data_q, d_data_d;
  logic grant_d, done;
  // Fetch wins a collision only once data has used up its streak allowance.
  assign grant_d = i_d_stb && !(i_i_stb && streak_q == SW'(D_MAX_STREAK));
  assign done = i_m_ack || to_q == TO_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    streak_d = streak_q;
    to_d = to_q;
    m_stb_d = m_stb_q;
    m_wr_en_d = m_wr_en_q;
    m_src_d = m_src_q;
    m_addr_d = m_addr_q;
    m_wr_data_d = m_wr_data_q;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    bus_err_d = 1'b0;
    i_data_d = '0;
    d_data_d = '0;
    case (state_q)
      S_IDLE: if (i_i_stb || i_d_stb) begin
        state_d = S_BUSY;
        to_d = '0;
        m_stb_d = 1'b1;
        m_src_d = grant_d;
        m_addr_d = grant_d ? i_d_addr : i_i_addr;
        m_wr_en_d = grant_d && i_d_wr_en;
        m_wr_data_d = grant_d ? i_d_wr_data : '0;
        streak_d = !(grant_d && i_i_stb) ? '0 :
                   streak_q == SW'(D_MAX_STREAK) ? streak_q : streak_q + 1'b1;
      end
      S_BUSY: begin
        to_d = to_q + 1'b1;
        if (done) begin
          state_d = S_RESP;
          m_stb_d = 1'b0;
          i_ack_d = !m_src_q;
          d_ack_d = m_src_q;
          bus_err_d = !i_m_ack;
          i_data_d = (i_m_ack && !m_src_q) ? i_m_data : '0;
          d_data_d = (i_m_ack && m_src_q && !m_wr_en_q) ? i_m_data : '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      streak_q <= '0;
      to_q <= '0;
      m_stb_q <= 1'b0;
      m_wr_en_q <= 1'b0;
      m_src_q <= 1'b0;
      m_addr_q <= '0;
      m_wr_data_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      bus_err_q <= 1'b0;
      i_data_q <= '0;
      d_data_q <= '0;
    end else begin
      state_q <= state_d;
      streak_q <= streak_d;
      to_q <= to_d;
      m_stb_q <= m_stb_d;
      m_wr_en_q <= m_wr_en_d;
      m_src_q <= m_src_d;
      m_addr_q <= m_addr_d;
      m_wr_data_q <= m_wr_data_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      bus_err_q <= bus_err_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
    end
  end
  assign o_i_ack = i_ack_q;
  assign o_i_data = i_data_q;
  assign o_d_ack = d_ack_q;
  assign o_d_data = d_data_q;
  assign o_m_stb = m_stb_q;
  assign o_m_wr_en = m_wr_en_q;
  assign o_m_addr = m_addr_q;
  assign o_m_wr_data = m_wr_data_q;
  assign o_m_src = m_src_q;
  assign o_bus_err = bus_err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant order, latency, timeout and reset behaviour.
module tb_mem_bus_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_i_stb = 0, i_d_stb = 0, i_d_wr_en = 0, i_m_ack;
  logic [31:0] i_i_addr = 0, i_d_addr = 0, i_d_wr_data = 0, i_m_data = 0;
  logic o_i_ack, o_d_ack, o_m_stb, o_m_wr_en, o_m_src, o_bus_err;
  logic [31:0] o_i_data, o_d_data, o_m_addr, o_m_wr_data;
  logic force_ack = 0, ack1 = 0;
  int mode = 0;
  int n_chk = 0, n_fail = 0;
  // mode 0: ack while o_m_stb is high, 1: ack one cycle after o_m_stb, 2: never ack
  assign i_m_ack = force_ack || (mode == 0 && o_m_stb) || (mode == 1 && ack1);
  always #5 clk = ~clk;
  always @(posedge clk) ack1 <= mode == 1 && o_m_stb && !ack1;
  mem_bus_arbiter #(.AW(32), .DW(32), .D_MAX_STREAK(4), .TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_i_stb(i_i_stb), .i_i_addr(i_i_addr), .o_i_ack(o_i_ack), .o_i_data(o_i_data),
    .i_d_stb(i_d_stb), .i_d_wr_en(i_d_wr_en), .i_d_addr(i_d_addr), .i_d_wr_data(i_d_wr_data),
    .o_d_ack(o_d_ack), .o_d_data(o_d_data),
    .o_m_stb(o_m_stb), .o_m_wr_en(o_m_wr_en), .o_m_addr(o_m_addr), .o_m_wr_data(o_m_wr_data),
    .o_m_src(o_m_src), .i_m_ack(i_m_ack), .i_m_data(i_m_data), .o_bus_err(o_bus_err)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] seq;
    int hi;
    seq = 10'b1111011110;
    tick;
    chk("rst_outputs", {o_i_ack, o_d_ack, o_m_stb, o_m_wr_en, o_m_src, o_bus_err}, 0);
    chk("rst_addr", o_m_addr, 0);
    rst_n = 1;
    // I read, memory acks one cycle after o_m_stb
    mode = 1;
    i_m_data = 32'hDEADBEEF;
    i_i_stb = 1; i_i_addr = 32'h100;
    tick;
    chk("i_rd_stb", o_m_stb, 1);
    chk("i_rd_addr", o_m_addr, 32'h100);
    chk("i_rd_src", o_m_src, 0);
    tick;
    chk("i_rd_wait", o_i_ack, 0);
    tick;
    chk("i_rd_ack", {o_i_ack, o_d_ack}, 2'b10);
    chk("i_rd_data", o_i_data, 32'hDEADBEEF);
    i_i_stb = 0;
    tick;
    chk("i_rd_after", {o_i_ack, o_i_data}, 0);
    // D write, zero-wait memory
    mode = 0;
    i_m_data = 32'hAAAA5555;
    i_d_stb = 1; i_d_wr_en = 1; i_d_addr = 32'h2000; i_d_wr_data = 32'h12345678;
    tick;
    chk("d_wr_en", o_m_wr_en, 1);
    chk("d_wr_data", o_m_wr_data, 32'h12345678);
    chk("d_wr_src", o_m_src, 1);
    chk("d_wr_addr", o_m_addr, 32'h2000);
    tick;
    chk("d_wr_ack", {o_i_ack, o_d_ack, o_bus_err}, 3'b010);
    chk("d_wr_data_out", o_d_data, 0);
    i_d_stb = 0; i_d_wr_en = 0;
    tick;
    chk("d_wr_after", o_d_ack, 0);
    // Both requesters held: fetch forced through after four data grants
    i_i_stb = 1; i_i_addr = 32'h600; i_d_stb = 1; i_d_addr = 32'h500;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk($sformatf("grant_src%0d", k), {o_m_stb, o_m_src}, {1'b1, seq[9-k]});
      tick;
      chk($sformatf("grant_ack%0d", k), {o_i_ack, o_d_ack}, seq[9-k] ? 2'b01 : 2'b10);
      chk($sformatf("grant_data%0d", k), seq[9-k] ? o_d_data : o_i_data, 32'hAAAA5555);
      if (k == 9) begin i_i_stb = 0; i_d_stb = 0; end
      tick;
    end
    chk("grant_idle", o_m_stb, 0);
    // Timeout: D read, memory silent
    mode = 2;
    i_m_data = 32'h0BADF00D;
    i_d_stb = 1; i_d_addr = 32'h300;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (o_m_stb) hi++;
      else break;
    end
    chk("to_stb_cycles", hi, 8);
    chk("to_ack", {o_i_ack, o_d_ack, o_bus_err}, 3'b011);
    chk("to_data", o_d_data, 0);
    i_d_stb = 0;
    tick;
    force_ack = 1;
    tick;
    force_ack = 0;
    chk("to_late_ack", {o_i_ack, o_d_ack, o_bus_err, o_m_stb}, 0);
    tick;
    chk("to_late_ack2", {o_i_ack, o_d_ack, o_bus_err, o_m_stb}, 0);
    // Reset while BUSY on a fetch
    i_i_stb = 1; i_i_addr = 32'h400;
    tick;
    chk("rst_mid_busy", {o_m_stb, o_m_addr}, {1'b1, 32'h400});
    #2 rst_n = 0;
    #1;
    chk("rst_mid_outputs", {o_i_ack, o_d_ack, o_m_stb, o_m_wr_en, o_m_src, o_bus_err}, 0);
    chk("rst_mid_addr", o_m_addr, 0);
    i_i_stb = 0;
    tick;
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("rst_after%0d", k), {o_i_ack, o_d_ack, o_m_stb}, 0);
    end
    // Spurious ack in IDLE, then a normal fetch proves the state stayed IDLE
    mode = 0;
    force_ack = 1;
    tick;
    force_ack = 0;
    chk("spur_ack", {o_i_ack, o_d_ack, o_m_stb}, 0);
    tick;
    chk("spur_ack2", {o_i_ack, o_d_ack, o_m_stb}, 0);
    i_m_data = 32'hCAFEF00D;
    i_i_stb = 1; i_i_addr = 32'h44;
    tick;
    chk("spur_grant", {o_m_stb, o_m_src}, 2'b10);
    tick;
    chk("spur_fetch_ack", {o_i_ack, o_d_ack}, 2'b10);
    chk("spur_fetch_data", o_i_data, 32'hCAFEF00D);
    i_i_stb = 0;
    tick;
    chk("spur_end", {o_i_ack, o_m_stb}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
